// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Front end of the 6502 core, sitting directly ahead of the opcode decoder.
//   Walks a 16-bit PC over an 8-bit memory port, works out the instruction
//   length (1..3 bytes) from the opcode's aaabbbcc fields, and assembles the
//   opcode plus up to two operand bytes. The assembled bundle is handed to the
//   decoder on a valid/ready handshake. A redirect from branch/jump
//   resolution flushes any partial bundle and restarts fetch at a new PC.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   mem_req_o      read request, held until mem_ack_i
//   mem_addr_o     read address, stable while mem_req_o=1
//   mem_ack_i      read data valid this cycle (ignored when mem_req_o=0)
//   mem_data_i     read data
//   redirect_i     flush and restart at redirect_pc_i (highest priority)
//   redirect_pc_i  restart PC
//   valid_o        instruction bundle valid
//   ready_i        decoder accepts bundle
//   opcode_o       opcode byte
//   data_o         operand bytes: [7:0] first, [15:8] second, unfetched = 0
//   len_o          instruction length 1..3
//   pc_o           address of the opcode byte
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'hC000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [7:0]        opcode_o,
  output logic [15:0]       data_o,
  output logic [1:0]        len_o,
  output logic [ADDR_W-1:0] pc_o
);

  typedef enum logic [1:0] {S_OP, S_LO, S_HI, S_OUT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_run;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [7:0]        r_opcode;
  logic [15:0]       r_data;
  logic [1:0]        r_len;
  logic              w_req;
  logic              w_ack;
  logic [1:0]        w_op_len;

  // Instruction length from the aaabbbcc opcode fields (c = op[1:0],
  // b = op[4:2]). The c=00, b=000 column mixes JSR (absolute operand),
  // BRK/RTI/RTS (no operand) and the immediate compares/loads.
  function automatic logic [1:0] insn_len(input logic [7:0] op);
    logic [2:0] b;
    logic [1:0] len;
    b   = op[4:2];
    len = 2'd1;
    case (op[1:0])
      2'b01: len = (b == 3'b011 || b == 3'b110 || b == 3'b111) ? 2'd3 : 2'd2;
      2'b10: begin
        case (b)
          3'b011, 3'b111:         len = 2'd3;
          3'b000, 3'b001, 3'b101: len = 2'd2;
          default:                len = 2'd1;
        endcase
      end
      2'b00: begin
        if (b == 3'b000) begin
          if (op == 8'h20)                                len = 2'd3;
          else if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
          else                                            len = 2'd2;
        end else begin
          case (b)
            3'b011, 3'b111:         len = 2'd3;
            3'b001, 3'b100, 3'b101: len = 2'd2;
            default:                len = 2'd1;
          endcase
        end
      end
      default: len = 2'd1;  // c=11: illegal opcodes, treated as operand-less
    endcase
    return len;
  endfunction

  assign w_op_len = insn_len(mem_data_i);
  // An ack only counts while a request is actually outstanding.
  assign w_ack    = mem_ack_i & w_req;

  // ---- state register -----------------------------------------------------
  // r_run keeps the request low while in reset and for the clock edge that
  // releases it, so the first request appears one clock after deassertion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_OP;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // ---- next-state logic ---------------------------------------------------
  // Redirect beats everything, including an ack or a consume in this cycle.
  always_comb begin
    w_next = r_state;
    if (redirect_i) begin
      w_next = S_OP;
    end else begin
      case (r_state)
        S_OP:    if (w_ack) w_next = (w_op_len == 2'd1) ? S_OUT : S_LO;
        S_LO:    if (w_ack) w_next = (r_len == 2'd2) ? S_OUT : S_HI;
        S_HI:    if (w_ack) w_next = S_OUT;
        S_OUT:   if (ready_i) w_next = S_OP;
        default: w_next = S_OP;
      endcase
    end
  end

  // ---- output logic -------------------------------------------------------
  always_comb begin
    w_req      = r_run && (r_state != S_OUT);
    mem_req_o  = w_req;
    mem_addr_o = r_pc;
    valid_o    = (r_state == S_OUT);
    opcode_o   = r_opcode;
    data_o     = r_data;
    len_o      = r_len;
    pc_o       = r_pc_out;
  end

  // ---- fetch datapath -----------------------------------------------------
  // The bundle registers are also reset so that outputs fall back to their
  // reset values the moment rst_i rises, even mid-fetch. PC increments wrap
  // modulo 2^ADDR_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc     <= RESET_PC;
      r_pc_out <= RESET_PC;
      r_opcode <= 8'h00;
      r_data   <= 16'h0000;
      r_len    <= 2'd1;
    end else if (redirect_i) begin
      r_pc <= redirect_pc_i;
    end else if (w_ack) begin
      case (r_state)
        S_OP: begin
          r_opcode <= mem_data_i;
          r_pc_out <= r_pc;
          r_pc     <= r_pc + ADDR_W'(1);
          r_len    <= w_op_len;
          r_data   <= 16'h0000;
        end
        S_LO: begin
          r_data[7:0] <= mem_data_i;
          r_pc        <= r_pc + ADDR_W'(1);
        end
        S_HI: begin
          r_data[15:8] <= mem_data_i;
          r_pc         <= r_pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A byte-array memory answers requests with a
//   programmable latency; captured bundles are compared against a table of
//   hand-computed {instruction bytes, expected len/data/pc} records, followed
//   by hand-written sequences for backpressure, async reset, redirect and PC
//   wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  opcode_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;
  logic [15:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hC000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .opcode_o      (opcode_o),
    .data_o        (data_o),
    .len_o         (len_o),
    .pc_o          (pc_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          nb;
    logic [1:0]  exp_len;
    logic [15:0] exp_data;
    logic [15:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] data;
    logic [1:0]  len;
    logic [15:0] pc;
    int          t;
  } bun_t;

  logic [7:0] mem [0:65535];
  vec_t       vecs [20];
  bun_t       got [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         lat = 0;
  int         wcnt = 0;
  int         acks = 0;
  bit         spurious = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: answer the memory port, log a bundle the decoder is taking,
  // then advance to the next falling edge.
  task automatic tick();
    bun_t b;
    if (mem_req_o) begin
      if (wcnt >= lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem[mem_addr_o];
        wcnt       = 0;
        acks++;
      end else begin
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        wcnt++;
      end
    end else begin
      mem_ack_i  = spurious;
      mem_data_i = 8'hFF;
      wcnt       = 0;
    end
    if (valid_o && ready_i) begin
      b.op = opcode_o; b.data = data_o; b.len = len_o; b.pc = pc_o; b.t = cyc;
      got.push_back(b);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({name, " bundle count"}, 64'(got.size()), 64'(n));
  endtask

  task automatic cmp_bundle(input string name, input int idx, input logic [7:0] op,
                            input logic [15:0] data, input logic [1:0] len,
                            input logic [15:0] pc);
    if (idx < got.size()) begin
      check({name, " opcode"}, 64'(got[idx].op), 64'(op));
      check({name, " data"},   64'(got[idx].data), 64'(data));
      check({name, " len"},    64'(got[idx].len), 64'(len));
      check({name, " pc"},     64'(got[idx].pc), 64'(pc));
    end else begin
      check({name, " missing"}, 64'(got.size()), 64'(idx + 1));
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] op, input logic [7:0] b1,
                         input logic [7:0] b2, input int nb, input logic [1:0] len,
                         input logic [15:0] data, input logic [15:0] pc);
    vecs[i].op = op; vecs[i].b1 = b1; vecs[i].b2 = b2; vecs[i].nb = nb;
    vecs[i].exp_len = len; vecs[i].exp_data = data; vecs[i].exp_pc = pc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [41:0] snap;
    int          hold;
    int          c0;
    int          k;

    rst_i = 1'b1; mem_ack_i = 1'b0; mem_data_i = 8'h00;
    redirect_i = 1'b0; redirect_pc_i = 16'h0000; ready_i = 1'b0;

    //           op     b1     b2    nb len data      pc
    set_vec( 0, 8'hAD, 8'h01, 8'h20, 3, 3, 16'h2001, 16'hC000);
    set_vec( 1, 8'hE8, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC003);
    set_vec( 2, 8'hA9, 8'h42, 8'h00, 2, 2, 16'h0042, 16'hC004);
    set_vec( 3, 8'h20, 8'h34, 8'h12, 3, 3, 16'h1234, 16'hC006);
    set_vec( 4, 8'h00, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC009);
    set_vec( 5, 8'hA2, 8'h7F, 8'h00, 2, 2, 16'h007F, 16'hC00A);
    set_vec( 6, 8'h0A, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC00C);
    set_vec( 7, 8'hAE, 8'h55, 8'hAA, 3, 3, 16'hAA55, 16'hC00D);
    set_vec( 8, 8'h9A, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC010);
    set_vec( 9, 8'hB6, 8'h10, 8'h00, 2, 2, 16'h0010, 16'hC011);
    set_vec(10, 8'h10, 8'hFE, 8'h00, 2, 2, 16'h00FE, 16'hC013);
    set_vec(11, 8'h2C, 8'h00, 8'h80, 3, 3, 16'h8000, 16'hC015);
    set_vec(12, 8'h03, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC018);
    set_vec(13, 8'h91, 8'h33, 8'h00, 2, 2, 16'h0033, 16'hC019);
    set_vec(14, 8'hB9, 8'hCD, 8'hAB, 3, 3, 16'hABCD, 16'hC01B);
    set_vec(15, 8'hC0, 8'h99, 8'h00, 2, 2, 16'h0099, 16'hC01E);
    set_vec(16, 8'h08, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC020);
    set_vec(17, 8'h1D, 8'h0F, 8'hF0, 3, 3, 16'hF00F, 16'hC021);
    set_vec(18, 8'h40, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC024);
    set_vec(19, 8'h60, 8'h00, 8'h00, 1, 1, 16'h0000, 16'hC025);

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    a = 16'hC000;
    for (int i = 0; i < 20; i++) begin
      mem[a] = vecs[i].op;
      if (vecs[i].nb > 1) mem[a + 16'd1] = vecs[i].b1;
      if (vecs[i].nb > 2) mem[a + 16'd2] = vecs[i].b2;
      a = a + 16'(vecs[i].nb);
    end

    // Reset values while rst_i is held
    repeat (2) @(negedge clk_i);
    check("rst mem_req",  64'(mem_req_o), 64'(0));
    check("rst valid",    64'(valid_o),   64'(0));
    check("rst opcode",   64'(opcode_o),  64'(8'h00));
    check("rst data",     64'(data_o),    64'(16'h0000));
    check("rst len",      64'(len_o),     64'(1));
    check("rst pc_o",     64'(pc_o),      64'(16'hC000));

    // Table run: ack every cycle, decoder always ready
    rst_i   = 1'b0;
    ready_i = 1'b1;
    tick();
    check("first req",  64'(mem_req_o),  64'(1));
    check("first addr", 64'(mem_addr_o), 64'(16'hC000));
    c0 = cyc;
    run_until(20, 400, "table");
    if (got.size() > 0) check("3-byte latency", 64'(got[0].t), 64'(c0 + 3));
    for (int i = 0; i < 20; i++)
      cmp_bundle($sformatf("vec%0d", i), i, vecs[i].op, vecs[i].exp_data,
                 vecs[i].exp_len, vecs[i].exp_pc);
    check("table next req",  64'(mem_req_o),  64'(1));
    check("table next addr", 64'(mem_addr_o), 64'(16'hC026));

    // Asynchronous reset while a bundle is being presented
    ready_i = 1'b0;
    tick();
    check("pre-rst valid",  64'(valid_o),  64'(1));
    check("pre-rst opcode", 64'(opcode_o), 64'(8'hEA));
    #2 rst_i = 1'b1;
    #1;
    check("async rst valid",  64'(valid_o),   64'(0));
    check("async rst req",    64'(mem_req_o), 64'(0));
    check("async rst opcode", 64'(opcode_o),  64'(8'h00));
    check("async rst len",    64'(len_o),     64'(1));
    check("async rst pc_o",   64'(pc_o),      64'(16'hC000));
    @(negedge clk_i);
    rst_i = 1'b0;

    // Slow memory (2 wait cycles per byte), 5 cycles of backpressure per
    // bundle, and stray acks whenever no request is outstanding
    got.delete();
    lat = 2; spurious = 1'b1; acks = 0; hold = 0; snap = '0;
    tick();
    k = 0;
    while (got.size() < 4 && k < 600) begin
      if (valid_o) begin
        if (hold == 0) snap = {opcode_o, data_o, len_o, pc_o};
        else check("hold stable", 64'({opcode_o, data_o, len_o, pc_o}), 64'(snap));
        check("hold no req", 64'(mem_req_o), 64'(0));
        ready_i = (hold >= 5);
        hold++;
      end else begin
        hold    = 0;
        ready_i = 1'b0;
      end
      tick();
      k++;
    end
    check("slow bundle count", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      cmp_bundle($sformatf("slow%0d", i), i, vecs[i].op, vecs[i].exp_data,
                 vecs[i].exp_len, vecs[i].exp_pc);
    check("slow byte reads", 64'(acks), 64'(9));
    lat = 0; spurious = 1'b0; ready_i = 1'b0;

    // Redirect while the first operand of 8D is outstanding
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    mem[16'hC000] = 8'h8D; mem[16'hC001] = 8'h34; mem[16'hC002] = 8'h12;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h77;
    got.delete();
    ready_i = 1'b1;
    tick();
    tick();
    check("in S_LO req",  64'(mem_req_o),  64'(1));
    check("in S_LO addr", 64'(mem_addr_o), 64'(16'hC001));
    redirect_i = 1'b1; redirect_pc_i = 16'h8000;
    tick();
    redirect_i = 1'b0;
    check("redirect req",  64'(mem_req_o),  64'(1));
    check("redirect addr", 64'(mem_addr_o), 64'(16'h8000));
    run_until(1, 50, "redirect");
    cmp_bundle("redirect", 0, 8'hA9, 16'h0077, 2'd2, 16'h8000);

    // PC wrap: 4C 00 90 at FFFF/0000/0001
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h90;
    redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
    tick();
    redirect_i = 1'b0;
    got.delete();
    check("wrap start addr", 64'(mem_addr_o), 64'(16'hFFFF));
    run_until(1, 50, "wrap");
    cmp_bundle("wrap", 0, 8'h4C, 16'h9000, 2'd3, 16'hFFFF);
    check("wrap next req",  64'(mem_req_o),  64'(1));
    check("wrap next addr", 64'(mem_addr_o), 64'(16'h0002));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage directly upstream of the opcode decoder.
- Reads instruction bytes from an 8-bit memory port, sequenced by a 16-bit PC.
- Determines 6502 instruction length (1-3 bytes) from the opcode's aaabbbcc fields and assembles opcode plus up to two operand bytes.
- Presents the complete instruction to the decoder on a valid/ready handshake; accepts PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 16'hC000, PC value loaded on reset.
- ADDR_W, 16, memory address width.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- mem_req_o, out, 1, read request; held until acked.
- mem_addr_o, out, ADDR_W, read address; stable while mem_req_o=1.
- mem_ack_i, in, 1, read data valid this cycle.
- mem_data_i, in, 8, read data, sampled when mem_ack_i=1.
- redirect_i, in, 1, flush and restart fetch at redirect_pc_i.
- redirect_pc_i, in, ADDR_W, new PC.
- valid_o, out, 1, instruction bundle valid.
- ready_i, in, 1, decoder accepts bundle.
- opcode_o, out, 8, opcode byte.
- data_o, out, 16, operand: [7:0]=first operand byte, [15:8]=second; unfetched bytes = 0.
- len_o, out, 2, instruction length 1..3.
- pc_o, out, ADDR_W, address of opcode byte.

Behaviour:
- Reset (async, rst_i=1):
  - pc=RESET_PC, state=S_OP.
  - mem_req_o=0, valid_o=0, opcode_o=8'h00, data_o=0, len_o=1, pc_o=RESET_PC.
  - First request issues in the first clock after rst_i deasserts.
- States: S_OP, S_LO, S_HI, S_OUT.
  - S_OP: mem_req_o=1, addr=pc. On ack: latch opcode, pc_o<=pc, pc<=pc+1, compute len, clear data_o. len=1 -> S_OUT; else -> S_LO.
  - S_LO: request pc. On ack: data_o[7:0]<=byte, pc<=pc+1. len=2 -> S_OUT; else -> S_HI.
  - S_HI: request pc. On ack: data_o[15:8]<=byte, pc<=pc+1 -> S_OUT.
  - S_OUT: valid_o=1, mem_req_o=0. On ready_i: valid_o<=0 -> S_OP (next request issues the following cycle). Bundle holds stable while ready_i=0.
- Throughput: with mem_ack_i in the same cycle as request, a 3-byte instruction takes 3 fetch cycles + 1 output cycle.
- Length rule (c=op[1:0], b=op[4:2]):
  - c=01: b in {011,110,111} -> 3; else -> 2.
  - c=10: b in {011,111} -> 3; b in {000,001,101} -> 2; b in {010,100,110} -> 1.
  - c=00, b=000: op=8'h20 -> 3; op in {00,40,60} -> 1; else -> 2.
  - c=00, other b: b in {011,111} -> 3; b in {001,100,101} -> 2; b in {010,110} -> 1.
  - c=11: 1 (illegal opcodes, no operands).
- PC arithmetic is 16-bit modulo; FFFF+1 wraps to 0000, no flag.
- redirect_i (highest priority, any state):
  - Next cycle: pc<=redirect_pc_i, state<=S_OP, valid_o<=0.
  - Partial bundle discarded; a mem_ack_i in the redirect cycle is ignored.
  - Redirect in S_OUT coincident with ready_i: the bundle counts as consumed, then the restart proceeds.
- mem_ack_i with mem_req_o=0 is ignored.
- Reset mid-fetch aborts immediately; outputs return to reset values asynchronously.

Test Plan:
- Reset: RESET_PC=C000, rst_i pulse -> all outputs at reset values during reset; first cycle after release mem_req_o=1, mem_addr_o=C000.
- 3-byte fetch: memory C000=AD,01,20, ack every cycle, ready_i=1 -> valid_o with opcode_o=AD, data_o=2001, len_o=3, pc_o=C000; next request at C003.
- Mixed lengths: sequence E8 (INX), A9 42 (LDA #), 20 34 12 (JSR) -> len_o 1,2,3; data_o 0000,0042,1234; pc_o C000,C001,C003.
- Backpressure / slow memory: ready_i=0 for 5 cycles, ack delayed 2 cycles per byte -> bundle held stable, mem_req_o=0 in S_OUT, no byte lost or duplicated.
- Redirect: redirect_i with redirect_pc_i=8000 during S_LO of 8D -> no valid_o for 8D; next request at 8000.
- Wrap: pc=FFFF fetching 4C 00 90 (bytes at FFFF,0000,0001) -> data_o=9000, len_o=3, next fetch at 0002.
